// File: rtl/fft_stage_sequencer.sv
// FFT stage sequencer: counts accepted samples per stage, steps through the butterfly
// stages of a frame and flags stage boundaries and frame completion.
module fft_stage_sequencer #(
  parameter int unsigned N_POINT    = 16,
  parameter int unsigned NUM_STAGE  = 4,
  parameter int unsigned CONTINUOUS = 0,
  localparam int unsigned SW = $clog2(N_POINT),
  localparam int unsigned GW = (NUM_STAGE > 1) ? $clog2(NUM_STAGE) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 start,
  input  logic                 valid_in,
  output logic                 busy,
  output logic [GW-1:0]        stage_idx,
  output logic [SW-1:0]        sample_idx,
  output logic [NUM_STAGE-1:0] bfly_enable,
  output logic                 stage_first,
  output logic                 stage_last,
  output logic                 frame_done
);

  typedef enum logic {StIdle, StRun} state_t;

  state_t                r_state, w_state_d;
  logic [GW-1:0]         r_stage_idx, w_stage_d;
  logic [SW-1:0]         r_sample_idx, w_sample_d;
  logic [NUM_STAGE-1:0]  r_bfly_enable, w_bfly_d;
  logic                  r_frame_done, w_done_d;
  logic                  w_smp_end, w_stg_end;

  assign w_smp_end = (r_sample_idx == SW'(N_POINT - 1));
  assign w_stg_end = (r_stage_idx == GW'(NUM_STAGE - 1));

  // Next-state: advance counters on accepted samples, wrap by explicit compare.
  always_comb begin
    w_state_d  = r_state;
    w_stage_d  = r_stage_idx;
    w_sample_d = r_sample_idx;
    w_done_d   = 1'b0;
    unique case (r_state)
      StIdle: begin
        // A sample presented together with start is not counted.
        if (start) w_state_d = StRun;
      end
      StRun: begin
        if (valid_in) begin
          if (w_smp_end) begin
            w_sample_d = '0;
            if (w_stg_end) begin
              w_stage_d = '0;
              w_done_d  = 1'b1;
              if (CONTINUOUS == 0) w_state_d = StIdle;
            end else begin
              w_stage_d = r_stage_idx + 1'b1;
            end
          end else begin
            w_sample_d = r_sample_idx + 1'b1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
    // Enable tracks the next stage so it changes on the same edge as stage_idx.
    w_bfly_d = (w_state_d == StRun) ? (NUM_STAGE'(1) << w_stage_d) : '0;
  end

  // State and registered outputs; clr behaves exactly like reset.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_state       <= StIdle;
      r_stage_idx   <= '0;
      r_sample_idx  <= '0;
      r_bfly_enable <= '0;
      r_frame_done  <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_stage_idx   <= w_stage_d;
      r_sample_idx  <= w_sample_d;
      r_bfly_enable <= w_bfly_d;
      r_frame_done  <= w_done_d;
    end
  end

  assign busy        = (r_state == StRun);
  assign stage_idx   = r_stage_idx;
  assign sample_idx  = r_sample_idx;
  assign bfly_enable = r_bfly_enable;
  assign frame_done  = r_frame_done;
  assign stage_first = busy && (r_sample_idx == '0);
  assign stage_last  = busy && w_smp_end;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: three configurations share one stimulus stream and are
// compared every cycle against a frame-level sample-count model.
module tb_fft_stage_sequencer;

  localparam int NP[3] = '{16, 16, 2};
  localparam int NS[3] = '{4, 4, 1};
  localparam int CT[3] = '{0, 1, 0};

  logic clk = 1'b0;
  logic rst = 1'b1, clr = 1'b0, start = 1'b0, valid_in = 1'b0;

  logic       busy0, first0, last0, done0;
  logic [1:0] stage0;
  logic [3:0] sample0, en0;
  logic       busy1, first1, last1, done1;
  logic [1:0] stage1;
  logic [3:0] sample1, en1;
  logic       busy2, first2, last2, done2;
  logic [0:0] stage2, sample2, en2;

  logic [31:0] o_stage[3], o_sample[3], o_en[3];
  logic        o_busy[3], o_first[3], o_last[3], o_done[3];

  int  n_tests = 0;
  int  n_fail  = 0;
  int  m_k[3];
  bit  m_run[3], m_done[3];

  always #5 clk = ~clk;

  fft_stage_sequencer #(.N_POINT(16), .NUM_STAGE(4), .CONTINUOUS(0)) u_oneshot (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .valid_in(valid_in),
    .busy(busy0), .stage_idx(stage0), .sample_idx(sample0), .bfly_enable(en0),
    .stage_first(first0), .stage_last(last0), .frame_done(done0)
  );

  fft_stage_sequencer #(.N_POINT(16), .NUM_STAGE(4), .CONTINUOUS(1)) u_cont (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .valid_in(valid_in),
    .busy(busy1), .stage_idx(stage1), .sample_idx(sample1), .bfly_enable(en1),
    .stage_first(first1), .stage_last(last1), .frame_done(done1)
  );

  fft_stage_sequencer #(.N_POINT(2), .NUM_STAGE(1), .CONTINUOUS(0)) u_tiny (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .valid_in(valid_in),
    .busy(busy2), .stage_idx(stage2), .sample_idx(sample2), .bfly_enable(en2),
    .stage_first(first2), .stage_last(last2), .frame_done(done2)
  );

  assign o_stage[0] = 32'(stage0);  assign o_sample[0] = 32'(sample0); assign o_en[0] = 32'(en0);
  assign o_stage[1] = 32'(stage1);  assign o_sample[1] = 32'(sample1); assign o_en[1] = 32'(en1);
  assign o_stage[2] = 32'(stage2);  assign o_sample[2] = 32'(sample2); assign o_en[2] = 32'(en2);
  assign o_busy[0] = busy0; assign o_first[0] = first0; assign o_last[0] = last0;
  assign o_busy[1] = busy1; assign o_first[1] = first1; assign o_last[1] = last1;
  assign o_busy[2] = busy2; assign o_first[2] = first2; assign o_last[2] = last2;
  assign o_done[0] = done0; assign o_done[1] = done1; assign o_done[2] = done2;

  task automatic chk(input string tag, input int i, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[inst %0d] at %0t: observed %0h expected %0h", tag, i, $time, obs, exp);
    end
  endtask

  // Model: a frame is just a running count of accepted samples; indices follow by div/mod.
  task automatic model_update(input bit s, input bit v, input bit c, input bit r);
    for (int i = 0; i < 3; i++) begin
      m_done[i] = 1'b0;
      if (r || c) begin
        m_run[i] = 1'b0;
        m_k[i]   = 0;
      end else if (!m_run[i]) begin
        if (s) m_run[i] = 1'b1;
      end else if (v) begin
        m_k[i]++;
        if (m_k[i] == NP[i] * NS[i]) begin
          m_k[i]    = 0;
          m_done[i] = 1'b1;
          m_run[i]  = (CT[i] != 0);
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      int st, sm;
      st = m_k[i] / NP[i];
      sm = m_k[i] % NP[i];
      chk("busy", i, 32'(o_busy[i]), 32'(m_run[i]));
      chk("stage_idx", i, o_stage[i], 32'(st));
      chk("sample_idx", i, o_sample[i], 32'(sm));
      chk("bfly_enable", i, o_en[i], m_run[i] ? (32'd1 << st) : 32'd0);
      chk("stage_first", i, 32'(o_first[i]), 32'(m_run[i] && sm == 0));
      chk("stage_last", i, 32'(o_last[i]), 32'(m_run[i] && sm == NP[i] - 1));
      chk("frame_done", i, 32'(o_done[i]), 32'(m_done[i]));
    end
  endtask

  task automatic step(input bit s, input bit v, input bit c, input bit r);
    start = s; valid_in = v; clr = c; rst = r;
    @(posedge clk);
    model_update(s, v, c, r);
    #1;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_k[i] = 0; m_run[i] = 1'b0; m_done[i] = 1'b0;
    end
    // Reset held two cycles
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    // One-shot frame: start then 64 back-to-back samples, then idle
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 64; n++) step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 4; n++) step(1'b0, 1'b0, 1'b0, 1'b0);
    // Stalled frame: alternate valid
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 132; n++) step(1'b0, n[0] == 1'b0, 1'b0, 1'b0);
    // Long run: 130 samples exercises continuous wrap
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 130; n++) step(1'b0, 1'b1, 1'b0, 1'b0);
    // Abort at stage 2 sample 5, then samples without start
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 37; n++) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 5; n++) step(1'b0, 1'b1, 1'b0, 1'b0);
    // start+valid together, then start while running
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 6; n++) step(1'b1, 1'b1, 1'b0, 1'b0);
    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 99) == 0, $urandom_range(0, 199) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
